// File: rtl/regfile_wb_queue.sv
// regfile_wb_queue
//   Sole driver of the register-file write port. Single-cycle datapath
//   writebacks (port A) always win; results from multi-cycle units (port B,
//   valid/ready) are buffered in a DEPTH-entry FIFO and drained into idle
//   write-port cycles. A later A write to the same register squashes older
//   queued entries (WAW). Pending live destinations are reported to decode
//   through chk_busy.
// Ports
//   clk, rst          clock; asynchronous active-low reset
//   a_id, a_data      datapath writeback (a_id==0: no write)
//   b_valid, b_ready  port B handshake
//   b_id, b_data      port B writeback (b_id==0: accepted, nothing stored)
//   write_id          regfile write_id (0: no write)
//   write_input       regfile write data
//   chk_id1, chk_id2  read-hazard queries
//   chk_busy          a queried non-zero reg has a live queued write
//   count             occupied FIFO slots (live + squashed)
module regfile_wb_queue #(
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [4:0]    a_id,
  input  logic [31:0]   a_data,
  input  logic          b_valid,
  output logic          b_ready,
  input  logic [4:0]    b_id,
  input  logic [31:0]   b_data,
  output logic [4:0]    write_id,
  output logic [31:0]   write_input,
  input  logic [4:0]    chk_id1,
  input  logic [4:0]    chk_id2,
  output logic          chk_busy,
  output logic [AW:0]   count
);

  localparam logic [AW:0] FULL = DEPTH[AW:0];

  logic          live_q [DEPTH];
  logic [4:0]    id_q   [DEPTH];
  logic [31:0]   data_q [DEPTH];
  logic [AW-1:0] head_q, tail_q;
  logic [AW:0]   count_q, count_d;

  logic head_live, pop, store, a_wr;
  logic busy1, busy2;

  assign a_wr      = (a_id != 5'd0);
  // Popped slots are cleared, so the live bit alone marks a stored live write.
  assign head_live = live_q[head_q];
  // A squashed head leaves every cycle; a live head only when A is idle.
  assign pop       = (count_q != '0) && (!head_live || !a_wr);
  assign b_ready   = rst && (count_q != FULL);
  assign store     = b_valid && b_ready && (b_id != 5'd0);
  assign count     = count_q;

  always_comb begin
    count_d = count_q;
    unique case ({store, pop})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_comb begin
    write_id    = '0;
    write_input = '0;
    if (rst) begin
      if (a_wr) begin
        write_id    = a_id;
        write_input = a_data;
      end else if (count_q != '0 && head_live) begin
        write_id    = id_q[head_q];
        write_input = data_q[head_q];
      end
    end
  end

  always_comb begin
    busy1 = 1'b0;
    busy2 = 1'b0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (live_q[i] && id_q[i] == chk_id1) busy1 = 1'b1;
      if (live_q[i] && id_q[i] == chk_id2) busy2 = 1'b1;
    end
    chk_busy = rst && (((chk_id1 != 5'd0) && busy1) || ((chk_id2 != 5'd0) && busy2));
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        live_q[i] <= 1'b0;
        id_q[i]   <= '0;
        data_q[i] <= '0;
      end
    end else begin
      // Squash and pop only clear live bits; the push writes the free tail
      // slot last, so an entry pushed at this edge survives a matching A write.
      for (int unsigned i = 0; i < DEPTH; i++) begin
        if (a_wr && live_q[i] && id_q[i] == a_id) live_q[i] <= 1'b0;
      end
      if (pop) begin
        live_q[head_q] <= 1'b0;
        head_q         <= head_q + AW'(1);
      end
      if (store) begin
        live_q[tail_q] <= 1'b1;
        id_q[tail_q]   <= b_id;
        data_q[tail_q] <= b_data;
        tail_q         <= tail_q + AW'(1);
      end
      count_q <= count_d;
    end
  end

endmodule
